// File: rtl/backprop_scheduler_pkg.sv
// rtl/backprop_scheduler_pkg.sv - shared types, defaults and reset weight init for the backprop scheduler
package backprop_scheduler_pkg;

  localparam int N_W_DEF     = 8;
  localparam int W_BITS_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;
  localparam int IDX_BITS    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } bp_state_e;

  // Reset value of weight k; callers truncate to W_BITS.
  function automatic logic [31:0] init_weight(input int k);
    return 32'(k + 1);
  endfunction

endpackage

// File: rtl/bp_watchdog.sv
// rtl/bp_watchdog.sv - per-weight WAIT cycle counter; expired_o flags the last allowed WAIT cycle
module bp_watchdog
  import backprop_scheduler_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_BITS = $clog2(TIMEOUT + 1);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_BITS'(TIMEOUT - 1));

endmodule

// File: rtl/backprop_scheduler.sv
// rtl/backprop_scheduler.sv - time-shares one backprop unit across N_W weights held in a flop weight file
module backprop_scheduler
  import backprop_scheduler_pkg::*;
#(
  parameter int N_W     = N_W_DEF,
  parameter int W_BITS  = W_BITS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    bp_start_i,
  input  logic                    ld_en_i,
  input  logic [IDX_BITS-1:0]     ld_idx_i,
  input  logic [W_BITS-1:0]       ld_w_i,
  input  logic [W_BITS-1:0]       bp_w_i,
  input  logic                    bp_done_i,
  output logic                    bp_clr_o,
  output logic                    bp_en_o,
  output logic [IDX_BITS-1:0]     bp_sel_o,
  output logic [W_BITS-1:0]       bp_w_o,
  output logic [N_W*W_BITS-1:0]   weights_o,
  output logic                    busy_o,
  output logic                    b_end_o,
  output logic                    err_o,
  output logic [N_W-1:0]          skip_mask_o
);

  bp_state_e             state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [W_BITS-1:0]     weight_q [N_W];
  logic [W_BITS-1:0]     weight_d [N_W];
  logic [W_BITS-1:0]     upd_w_q, upd_w_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [N_W-1:0]        skip_q, skip_d;
  logic                  clr_q, clr_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  bend_q, bend_d;
  logic                  rdy_q, rdy_d;
  logic                  wd_expired;

  bp_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == ST_ISSUE),
    .en_i      (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    weight_d = weight_q;
    upd_w_d  = upd_w_q;
    valid_d  = valid_q;
    err_d    = err_q;
    skip_d   = skip_q;
    // Holds off sweeps until one full edge has passed since reset release.
    rdy_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (ld_en_i && (int'(ld_idx_i) < N_W)) begin
          weight_d[ld_idx_i] = ld_w_i;
        end
        if (bp_start_i && rdy_q) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          err_d   = 1'b0;
          skip_d  = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done has priority over an expiring watchdog in the same cycle.
        if (bp_done_i) begin
          valid_d = 1'b1;
          upd_w_d = bp_w_i;
          state_d = ST_WRITE;
        end else if (wd_expired) begin
          valid_d = 1'b0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (valid_q) begin
          weight_d[idx_q] = upd_w_q;
        end else begin
          skip_d[idx_q] = 1'b1;
          err_d         = 1'b1;
        end
        if (idx_q == IDX_BITS'(N_W - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_BITS'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clr_d  = (state_d == ST_ISSUE);
    en_d   = (state_d == ST_WAIT);
    busy_d = (state_d != ST_IDLE);
    bend_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int k = 0; k < N_W; k++) begin
        weight_q[k] <= W_BITS'(init_weight(k));
      end
      upd_w_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      skip_q  <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      bend_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      weight_q <= weight_d;
      upd_w_q  <= upd_w_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
      clr_q    <= clr_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      bend_q   <= bend_d;
      rdy_q    <= rdy_d;
    end
  end

  for (genvar k = 0; k < N_W; k++) begin : g_pack
    assign weights_o[k*W_BITS +: W_BITS] = weight_q[k];
  end

  assign bp_sel_o    = idx_q;
  assign bp_w_o      = weight_q[idx_q];
  assign bp_clr_o    = clr_q;
  assign bp_en_o     = en_q;
  assign busy_o      = busy_q;
  assign b_end_o     = bend_q;
  assign err_o       = err_q;
  assign skip_mask_o = skip_q;

endmodule

// File: doc/backprop_scheduler.md
BACKPROP_SCHEDULER -- requirements
Module: backprop_scheduler

Interface
REQ-001 SHALL have parameter N_W, default 8, meaning the number of hidden-to-output weights time-shared on one backprop unit.
REQ-002 SHALL have parameter W_BITS, default 8, meaning the width of one weight.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum WAIT cycles per weight before it is skipped.
REQ-004 SHALL have ports: clk_i  in  1  clock; the single clock.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 bp_start_i  in  1  single-cycle pulse that starts a backprop sweep.
REQ-007 ld_en_i, ld_idx_i, ld_w_i  in  1, 3, W_BITS  host weight load: enable, weight index, weight value.
REQ-008 bp_w_i, bp_done_i  in  W_BITS, 1  updated weight and its done flag, both from the backprop unit.
REQ-009 bp_clr_o, bp_en_o  out  1, 1  backprop unit clear (zero-reset) pulse and backprop unit enable.
REQ-010 bp_sel_o  out  3  hidden-neuron index currently being updated.
REQ-011 bp_w_o  out  W_BITS  current weight fed to the backprop unit.
REQ-012 weights_o  out  N_W*W_BITS  packed weight file; weight k occupies bits [k*W_BITS +: W_BITS].
REQ-013 busy_o, b_end_o, err_o  out  1, 1, 1  sweep busy, sweep-done pulse, sticky timeout flag.
REQ-014 skip_mask_o  out  N_W  per-weight timeout-skip flags.

Function
REQ-015 The FSM SHALL have five states: IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-016 IDLE transition: bp_start_i=1 -> ISSUE; on that edge idx<=0, err_o<=0, skip_mask_o<=0.
REQ-017 ISSUE output and transition: bp_clr_o=1 for exactly 1 cycle; unconditional -> WAIT.
REQ-018 WAIT output: bp_en_o=1 in every WAIT cycle; the timeout counter increments each WAIT cycle.
REQ-019 WAIT transition: bp_done_i=1 -> WRITE with the update flagged valid; else counter==TIMEOUT-1 -> WRITE with the update flagged invalid.
REQ-020 WRITE, valid update: weight[idx]<=bp_w_i.
REQ-021 WRITE, invalid update: weight[idx] is unchanged, skip_mask_o[idx]<=1, err_o<=1.
REQ-022 WRITE transition: idx==N_W-1 -> DONE; else idx<=idx+1 -> ISSUE.
REQ-023 DONE: b_end_o=1 for exactly 1 cycle; -> IDLE.
REQ-024 bp_sel_o SHALL equal idx; bp_w_o SHALL equal weight[idx] combinationally.
REQ-025 busy_o=1 in every state except IDLE.
REQ-026 Timing: bp_start_i sampled at edge 0 with an immediate bp_done_i every weight gives b_end_o high in the cycle after edge 3*N_W+1 (cycle 25 for N_W=8).
REQ-027 Timeout path: per skipped weight, ISSUE 1 + WAIT TIMEOUT + WRITE 1 cycles.
REQ-028 bp_start_i SHALL be ignored when not in IDLE; no restart and no state corruption.
REQ-029 bp_done_i SHALL be ignored outside WAIT.
REQ-030 If bp_done_i is asserted in the same cycle the counter reaches TIMEOUT-1, done SHALL win: the weight is written and no skip is flagged.
REQ-031 The timeout counter SHALL clear on entry to ISSUE; its width is ceil(log2(TIMEOUT+1)).
REQ-032 ld_en_i SHALL write ld_w_i to weight[ld_idx_i] only in IDLE; it SHALL be ignored while busy_o=1.
REQ-033 ld_idx_i>=N_W SHALL be ignored.
REQ-034 If ld_en_i and bp_start_i are asserted in the same IDLE cycle, the load SHALL commit and the sweep SHALL start; the sweep then uses the loaded value.
REQ-035 Weights SHALL be stored unsigned W_BITS wide with no arithmetic on them; bp_w_i is stored verbatim.

Reset
REQ-036 On rst_i=0 (asynchronous) the FSM SHALL go to IDLE and idx/counter SHALL clear to 0.
REQ-037 On reset, err_o=0 and skip_mask_o=0.
REQ-038 On reset, bp_clr_o=bp_en_o=busy_o=b_end_o=0.
REQ-039 On reset, weight[k] SHALL equal k+1 (weights_o=64'h0807060504030201 at defaults).
REQ-040 Reset asserted mid-sweep SHALL abort immediately with no b_end_o pulse; partially updated weights SHALL be reinitialised.
REQ-041 After rst_i deasserts, the first bp_start_i SHALL be accepted no earlier than the second rising edge.

Structure
REQ-042 The shared package SHALL hold the state enum, N_W/W_BITS/TIMEOUT defaults, IDX_BITS, and the reset weight-init function.
REQ-043 The timeout counter SHALL be one sub-module, bp_watchdog (clear, count-enable, expired output).
REQ-044 The weight file SHALL be flops, not RAM.

Verification
REQ-045 Reset, then bp_start_i with bp_done_i=1 and bp_w_i=8'hA0+idx in every WAIT cycle -> weights_o=64'hA7A6A5A4A3A2A1A0, b_end_o in cycle 25, err_o=0.
REQ-046 TIMEOUT=4; bp_done_i never asserted for idx 3 -> weight[3] stays 4, skip_mask_o=8'h08, err_o=1, other weights updated.
REQ-047 bp_done_i coincides with the counter reaching TIMEOUT-1 at idx 0 -> weight[0]=bp_w_i, skip_mask_o[0]=0.
REQ-048 bp_start_i and ld_en_i pulsed mid-sweep -> no restart, weights are not loaded, exactly one b_end_o.
REQ-049 rst_i=0 while idx=5 in WAIT -> same cycle: busy_o=0, bp_en_o=0, weights_o=64'h0807060504030201; no b_end_o.
REQ-050 ld_en_i with ld_idx_i=2, ld_w_i=8'h55 in IDLE, then a sweep with bp_w_i=bp_w_o+1 -> weight[2]=8'h56.
